locked_reg_unlock_ctrl: RTL and testbench

Write-gating controller that sits directly upstream of the locked register flop (async-reset, enable-gated, `$adffe`-style). It accepts write requests from the bus side and produces the flop's `write_en` and data. Writes reach the register only after a two-word key sequence unlocks it, and only within a bounded window. Repeated key failures force a sticky lockout that only reset clears.

---
 rtl/locked_reg_unlock_ctrl_if.sv | 37 +++
 rtl/locked_reg_unlock_ctrl.sv | 172 +++++++++++++++++
 tb/tb_locked_reg_unlock_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/locked_reg_unlock_ctrl_if.sv
// ---------------------------------------------------------------------------
// locked_reg_unlock_ctrl_if
// Bus bundle between the key/write requester and the unlock controller.
//   master modport : drives key_valid/key_data, wr_req/wr_data, lock_req;
//                    observes write_en, data_in_q, unlocked, lockout, viol,
//                    fail_cnt.
//   slave modport  : the controller side (directions reversed).
// Parameters WIDTH and MAX_FAILS must match the controller instance.
// ---------------------------------------------------------------------------
interface locked_reg_unlock_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_FAILS = 3
);
  localparam int FCW = $clog2(MAX_FAILS + 1);

  logic             key_valid;
  logic [WIDTH-1:0] key_data;
  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             lock_req;
  logic             write_en;
  logic [WIDTH-1:0] data_in_q;
  logic             unlocked;
  logic             lockout;
  logic             viol;
  logic [FCW-1:0]   fail_cnt;

  modport master (
    output key_valid, key_data, wr_req, wr_data, lock_req,
    input  write_en, data_in_q, unlocked, lockout, viol, fail_cnt
  );

  modport slave (
    input  key_valid, key_data, wr_req, wr_data, lock_req,
    output write_en, data_in_q, unlocked, lockout, viol, fail_cnt
  );
endinterface

// File: rtl/locked_reg_unlock_ctrl.sv
// ---------------------------------------------------------------------------
// locked_reg_unlock_ctrl
// Write-gating controller in front of a locked, enable-gated register flop.
// A two-word key (KEY0 then KEY1 within ARM_WINDOW cycles) opens the register
// for UNLOCK_WINDOW cycles; MAX_FAILS key failures force a sticky lockout
// that only resetn clears.
//
// Ports:
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset
//   bus     : locked_reg_unlock_ctrl_if.slave
//             in : key_valid, key_data, wr_req, wr_data, lock_req
//             out: write_en (1-cycle pulse), data_in_q, unlocked, lockout,
//                  viol (1-cycle pulse), fail_cnt
// All outputs are registered.
//
// Build option: define LOCKED_REG_AUTO_RELOCK_EN to relock on every accepted
// write (one write per unlock). Undefined: writes allowed until the window
// expires or lock_req asserts.
// ---------------------------------------------------------------------------
module locked_reg_unlock_ctrl #(
  parameter int              WIDTH         = 8,
  parameter logic [WIDTH-1:0] KEY0         = 8'hA5,
  parameter logic [WIDTH-1:0] KEY1         = 8'h3C,
  parameter int              ARM_WINDOW    = 4,
  parameter int              UNLOCK_WINDOW = 16,
  parameter int              MAX_FAILS     = 3
) (
  input  logic                     clk,
  input  logic                     resetn,
  locked_reg_unlock_ctrl_if.slave  bus
);
  localparam int FCW  = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (ARM_WINDOW > UNLOCK_WINDOW) ? ARM_WINDOW : UNLOCK_WINDOW;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_ARMED    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  state_t           state_q,    state_d;
  logic [TW-1:0]    timer_q,    timer_d;
  logic [FCW-1:0]   fail_cnt_q, fail_cnt_d;
  logic             write_en_q, write_en_d;
  logic [WIDTH-1:0] data_q,     data_d;
  logic             unlocked_q, unlocked_d;
  logic             lockout_q,  lockout_d;
  logic             viol_q,     viol_d;
  logic             accept_s;
  logic             fail_s;

  // Write is accepted only from a settled UNLOCKED state with no relock request.
  assign accept_s = bus.wr_req && (state_q == ST_UNLOCKED) && !bus.lock_req;

  // Next-state, timer, failure counter and output decode.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    fail_cnt_d = fail_cnt_q;
    fail_s     = 1'b0;

    case (state_q)
      ST_LOCKED: begin
        if (bus.key_valid) begin
          if (bus.key_data == KEY0) begin
            state_d = ST_ARMED;
            timer_d = TW'(ARM_WINDOW);
          end else begin
            fail_s = 1'b1;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_ARMED: begin
        if (bus.key_valid && (bus.key_data == KEY1)) begin
          state_d    = ST_UNLOCKED;
          timer_d    = TW'(UNLOCK_WINDOW);
          fail_cnt_d = '0;
        end else if (bus.key_valid || (timer_q <= TW'(1))) begin
          // Wrong second word, or the last armed cycle passed without KEY1.
          fail_s  = 1'b1;
          state_d = ST_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_UNLOCKED: begin
        if (bus.lock_req) begin
          state_d = ST_LOCKED;
          timer_d = '0;
`ifdef LOCKED_REG_AUTO_RELOCK_EN
        end else if (accept_s) begin
          state_d = ST_LOCKED;
          timer_d = '0;
`endif
        end else if (timer_q <= TW'(1)) begin
          // Current cycle is the last of the window; a write here still lands.
          state_d = ST_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_LOCKOUT: begin
        state_d = ST_LOCKOUT;
      end
      default: begin
        state_d = ST_LOCKOUT;
        timer_d = '0;
      end
    endcase

    // A failure that reaches MAX_FAILS overrides the listed destination.
    if (fail_s) begin
      if (fail_cnt_q >= FCW'(MAX_FAILS - 1)) begin
        fail_cnt_d = FCW'(MAX_FAILS);
        state_d    = ST_LOCKOUT;
        timer_d    = '0;
      end else begin
        fail_cnt_d = fail_cnt_q + FCW'(1);
      end
    end else begin
      fail_cnt_d = fail_cnt_d;
    end

    write_en_d = accept_s;
    viol_d     = bus.wr_req && !accept_s;
    if (accept_s) begin
      data_d = bus.wr_data;
    end else begin
      data_d = data_q;
    end
    unlocked_d = (state_d == ST_UNLOCKED);
    lockout_d  = (state_d == ST_LOCKOUT);
  end

  // State and registered outputs; reset also kills a pending write_en pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_LOCKED;
      timer_q    <= '0;
      fail_cnt_q <= '0;
      write_en_q <= 1'b0;
      data_q     <= '0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      viol_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      fail_cnt_q <= fail_cnt_d;
      write_en_q <= write_en_d;
      data_q     <= data_d;
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
      viol_q     <= viol_d;
    end
  end

  assign bus.write_en  = write_en_q;
  assign bus.data_in_q = data_q;
  assign bus.unlocked  = unlocked_q;
  assign bus.lockout   = lockout_q;
  assign bus.viol      = viol_q;
  assign bus.fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_locked_reg_unlock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_locked_reg_unlock_ctrl
// Table-driven vectors plus hand-written multi-cycle sequences. Each step
// pushes its expected post-edge outputs into a queue and pops/compares them
// once the clock edge has produced the DUT response.
// ---------------------------------------------------------------------------
module tb_locked_reg_unlock_ctrl;
`ifdef LOCKED_REG_AUTO_RELOCK_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct {
    logic       kv;
    logic [7:0] kd;
    logic       wr;
    logic [7:0] wd;
    logic       lk;
    logic       we;
    logic [7:0] dq;
    logic       unl;
    logic       lo;
    logic       vi;
    logic [1:0] fc;
  } vec_t;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;
  vec_t exp_q[$];
  vec_t tbl[14];

  locked_reg_unlock_ctrl_if #(.WIDTH(8), .MAX_FAILS(3)) bus ();

  locked_reg_unlock_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic vec_t mk(logic kv, logic [7:0] kd, logic wr, logic [7:0] wd,
                              logic lk, logic we, logic [7:0] dq, logic unl,
                              logic lo, logic vi, logic [1:0] fc);
    vec_t v;
    v.kv = kv; v.kd = kd; v.wr = wr; v.wd = wd; v.lk = lk;
    v.we = we; v.dq = dq; v.unl = unl; v.lo = lo; v.vi = vi; v.fc = fc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_outs(string tag, vec_t e);
    chk({tag, ".write_en"},  32'(bus.write_en),  32'(e.we));
    chk({tag, ".data_in_q"}, 32'(bus.data_in_q), 32'(e.dq));
    chk({tag, ".unlocked"},  32'(bus.unlocked),  32'(e.unl));
    chk({tag, ".lockout"},   32'(bus.lockout),   32'(e.lo));
    chk({tag, ".viol"},      32'(bus.viol),      32'(e.vi));
    chk({tag, ".fail_cnt"},  32'(bus.fail_cnt),  32'(e.fc));
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(string tag, vec_t v);
    vec_t e;
    bus.key_valid = v.kv;
    bus.key_data  = v.kd;
    bus.wr_req    = v.wr;
    bus.wr_data   = v.wd;
    bus.lock_req  = v.lk;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk_outs(tag, e);
    end
  endtask

  task automatic idle(string tag, logic unl, logic [7:0] dq, logic [1:0] fc);
    step(tag, mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, dq, unl, 1'b0, 1'b0, fc));
  endtask

  task automatic key(string tag, logic [7:0] kd, logic unl, logic [7:0] dq, logic [1:0] fc);
    step(tag, mk(1'b1, kd, 1'b0, 8'h00, 1'b0, 1'b0, dq, unl, 1'b0, 1'b0, fc));
  endtask

  task automatic do_reset(string tag);
    resetn = 1'b0;
    #1;
    chk_outs(tag, mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    n_checks = 0;
    n_fail   = 0;
    resetn        = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_data  = 8'h00;
    bus.wr_req    = 1'b0;
    bus.wr_data   = 8'h00;
    bus.lock_req  = 1'b0;

    d = AR ? 8'h77 : 8'h88;
    //            kv    kd     wr    wd     lk    we    dq     unl   lo    vi    fc
    tbl[0]  = mk(1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0);
    tbl[1]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    tbl[2]  = mk(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    tbl[3]  = mk(1'b1, 8'h3C, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0);
    tbl[4]  = mk(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b1, 8'h77, !AR,  1'b0, 1'b0, 2'd0);
    tbl[5]  = mk(1'b0, 8'h00, 1'b1, 8'h88, 1'b0, !AR,  d,     !AR,  1'b0, AR,   2'd0);
    tbl[6]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, d,     !AR,  1'b0, 1'b0, 2'd0);
    tbl[7]  = mk(1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0, d,     1'b0, 1'b0, 1'b1, 2'd0);
    tbl[8]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, d,     1'b0, 1'b0, 1'b0, 2'd0);
    tbl[9]  = mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, d,     1'b0, 1'b0, 1'b0, 2'd1);
    tbl[10] = mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, d,     1'b0, 1'b0, 1'b0, 2'd2);
    tbl[11] = mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, d,     1'b0, 1'b1, 1'b0, 2'd3);
    tbl[12] = mk(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, d,     1'b0, 1'b1, 1'b0, 2'd3);
    tbl[13] = mk(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, d,     1'b0, 1'b1, 1'b0, 2'd3);

    do_reset("reset0");
    for (int i = 0; i < 14; i++) begin
      step($sformatf("tbl%0d", i), tbl[i]);
    end

    // Reset clears the sticky lockout and everything else.
    do_reset("reset_lockout");

    // Unlock window: unlocked high for exactly 16 cycles; write on the last
    // cycle is accepted, the next one is rejected.
    key("win_k0", 8'hA5, 1'b0, 8'h00, 2'd0);
    key("win_k1", 8'h3C, 1'b1, 8'h00, 2'd0);
    for (int i = 0; i < 15; i++) begin
      idle($sformatf("win_idle%0d", i), 1'b1, 8'h00, 2'd0);
    end
    step("win_last_wr", mk(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 2'd0));
    step("win_late_wr", mk(1'b0, 8'h00, 1'b1, 8'h6B, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 2'd0));

    // ARMED timeout after 4 cycles, then a late KEY1 is a second failure.
    key("arm_k0", 8'hA5, 1'b0, 8'h5A, 2'd0);
    for (int i = 0; i < 3; i++) begin
      idle($sformatf("arm_idle%0d", i), 1'b0, 8'h5A, 2'd0);
    end
    idle("arm_timeout", 1'b0, 8'h5A, 2'd1);
    idle("arm_after", 1'b0, 8'h5A, 2'd1);
    key("arm_late_k1", 8'h3C, 1'b0, 8'h5A, 2'd2);

    // KEY1 on the last ARMED cycle is accepted and clears fail_cnt.
    key("edge_k0", 8'hA5, 1'b0, 8'h5A, 2'd2);
    for (int i = 0; i < 3; i++) begin
      idle($sformatf("edge_idle%0d", i), 1'b0, 8'h5A, 2'd2);
    end
    key("edge_k1", 8'h3C, 1'b1, 8'h5A, 2'd0);

    // lock_req wins over a simultaneous write.
    step("lock_wr", mk(1'b0, 8'h00, 1'b1, 8'hC3, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 2'd0));

    // Reset mid-pulse clears a pending write_en immediately.
    key("rst_k0", 8'hA5, 1'b0, 8'h5A, 2'd0);
    key("rst_k1", 8'h3C, 1'b1, 8'h5A, 2'd0);
    step("rst_wr", mk(1'b0, 8'h00, 1'b1, 8'hE1, 1'b0, 1'b1, 8'hE1, !AR, 1'b0, 1'b0, 2'd0));
    do_reset("reset_mid_pulse");
    idle("post_reset", 1'b0, 8'h00, 2'd0);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
